// File: rtl/alu_core.sv
// 8-bit single-cycle ALU: combinational result on check, registered copy on Result.
// Optional ALU_FLAGS_EN adds registered zero/carry/negative flags.
module alu_core #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       Inst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] BusWires,
  output logic [WIDTH-1:0] check,
  output logic [WIDTH-1:0] Result
`ifdef ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             carry,
  output logic             negative
`endif
);

  localparam logic [3:0] OpMul  = 4'b0000;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpSub  = 4'b0011;
  localparam logic [3:0] OpAnd  = 4'b0100;
  localparam logic [3:0] OpNand = 4'b0101;
  localparam logic [3:0] OpOr   = 4'b0110;
  localparam logic [3:0] OpNor  = 4'b0111;
  localparam logic [3:0] OpRor  = 4'b1010;
  localparam logic [3:0] OpRol  = 4'b1011;
  localparam logic [3:0] OpNot  = 4'b1100;
  localparam logic [3:0] OpShl  = 4'b1101;
  localparam logic [3:0] OpShr  = 4'b1110;

  logic load;

  always_comb begin
    check = '0;
    load  = 1'b1;
    case (Inst)
      OpMul:   check = A * BusWires;
      OpAdd:   check = A + BusWires;
      OpSub:   check = A - BusWires;
      OpAnd:   check = A & BusWires;
      OpNand:  check = ~(A & BusWires);
      OpOr:    check = A | BusWires;
      OpNor:   check = ~(A | BusWires);
      OpRor:   check = {A[0], A[WIDTH-1:1]};
      OpRol:   check = {A[WIDTH-2:0], A[WIDTH-1]};
      OpNot:   check = ~A;
      OpShl:   check = {A[WIDTH-2:0], 1'b0};
      OpShr:   check = {1'b0, A[WIDTH-1:1]};
      default: load  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Result <= '0;
    end else if (load) begin
      Result <= check;
    end
  end

`ifdef ALU_FLAGS_EN
  logic [2*WIDTH-1:0] prod_full;
  logic               carry_c;

  assign prod_full = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, BusWires};

  always_comb begin
    carry_c = 1'b0;
    case (Inst)
      // A + B overflows exactly when A exceeds the ones' complement of B.
      OpAdd:        carry_c = A > ~BusWires;
      OpSub:        carry_c = A < BusWires;
      OpMul:        carry_c = prod_full > {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
      OpShl, OpRol: carry_c = A[WIDTH-1];
      OpShr, OpRor: carry_c = A[0];
      default:      carry_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero     <= 1'b0;
      carry    <= 1'b0;
      negative <= 1'b0;
    end else if (load) begin
      zero     <= (check == '0);
      carry    <= carry_c;
      negative <= check[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed test-plan steps then randomized ops
// against an arithmetic reference model.
module tb_alu_core;

  logic       clk;
  logic       rst_n;
  logic [3:0] Inst;
  logic [7:0] A;
  logic [7:0] BusWires;
  logic [7:0] check;
  logic [7:0] Result;
`ifdef ALU_FLAGS_EN
  logic       zero, carry, negative;
  logic       exp_z, exp_c, exp_n;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_res;

  alu_core #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Inst     (Inst),
    .A        (A),
    .BusWires (BusWires),
    .check    (check),
    .Result   (Result)
`ifdef ALU_FLAGS_EN
    ,
    .zero     (zero),
    .carry    (carry),
    .negative (negative)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference value from plain arithmetic; -1 marks an undefined opcode.
  function automatic int model(input int op, input int a, input int b);
    case (op)
      0:       return (a * b) % 256;
      2:       return (a + b) % 256;
      3:       return (a - b + 256) % 256;
      4:       return a & b;
      5:       return 255 - (a & b);
      6:       return a | b;
      7:       return 255 - (a | b);
      10:      return (a / 2) + (a % 2) * 128;
      11:      return (a * 2) % 256 + a / 128;
      12:      return 255 - a;
      13:      return (a * 2) % 256;
      14:      return a / 2;
      default: return -1;
    endcase
  endfunction

  function automatic int carry_model(input int op, input int a, input int b);
    case (op)
      0:       return (a * b > 255) ? 1 : 0;
      2:       return (a + b > 255) ? 1 : 0;
      3:       return (a < b) ? 1 : 0;
      11, 13:  return (a >= 128) ? 1 : 0;
      10, 14:  return a % 2;
      default: return 0;
    endcase
  endfunction

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (Inst=%b A=%h B=%h)", tag, obs, exp, Inst, A,
             BusWires);
    end
  endtask

`ifdef ALU_FLAGS_EN
  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
`endif

  // Drive inputs between edges, check combinational output, then check the register.
  task automatic step(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int m;
    Inst     = op;
    A        = a;
    BusWires = b;
    #1;
    m = model(int'(op), int'(a), int'(b));
    chk8("check", check, (m < 0) ? 8'h00 : m[7:0]);
    @(posedge clk);
    #1;
    if (m >= 0) begin
      exp_res = m[7:0];
`ifdef ALU_FLAGS_EN
      exp_z = (m == 0);
      exp_n = (m >= 128);
      exp_c = (carry_model(int'(op), int'(a), int'(b)) != 0);
`endif
    end
    chk8("Result", Result, exp_res);
`ifdef ALU_FLAGS_EN
    chk1("zero", zero, exp_z);
    chk1("carry", carry, exp_c);
    chk1("negative", negative, exp_n);
`endif
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    exp_res = 8'h00;
`ifdef ALU_FLAGS_EN
    exp_z = 1'b0;
    exp_c = 1'b0;
    exp_n = 1'b0;
`endif
    chk8("reset_Result", Result, 8'h00);
    chk8("reset_check", check, (model(int'(Inst), int'(A), int'(BusWires)) < 0) ? 8'h00 :
         8'(model(int'(Inst), int'(A), int'(BusWires))));
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    Inst     = 4'b0010;
    A        = 8'h12;
    BusWires = 8'h34;
    exp_res  = 8'h00;
`ifdef ALU_FLAGS_EN
    exp_z = 1'b0;
    exp_c = 1'b0;
    exp_n = 1'b0;
`endif
    #1;
    chk8("init_Result", Result, 8'h00);
    chk8("init_check", check, 8'h46);
    @(posedge clk);
    #1;
    chk8("held_in_reset", Result, 8'h00);
    rst_n = 1'b1;

    // Directed test plan.
    step(4'b0000, 8'h04, 8'h02);
    step(4'b0000, 8'h08, 8'h04);
    step(4'b0010, 8'h5F, 8'h60);
    step(4'b0011, 8'h3D, 8'h01);
    step(4'b0011, 8'h1C, 8'h0C);
    step(4'b0010, 8'hFF, 8'h01);
    step(4'b0011, 8'h00, 8'h01);
    step(4'b0101, 8'h3F, 8'h01);
    step(4'b0110, 8'hBD, 8'h00);
    step(4'b0111, 8'hBD, 8'h1F);
    step(4'b1100, 8'h4F, 8'h5A);
    step(4'b1010, 8'h01, 8'hFF);
    step(4'b1010, 8'h1E, 8'h00);
    step(4'b1011, 8'h01, 8'h00);
    step(4'b1011, 8'h80, 8'h00);
    step(4'b1101, 8'h1E, 8'h00);
    step(4'b1110, 8'h01, 8'h00);
    step(4'b1110, 8'h1E, 8'h00);
    step(4'b0000, 8'h20, 8'h10);
    step(4'b0100, 8'h3D, 8'h71);
    chk8("and_loaded", Result, 8'h31);
    step(4'b1111, 8'h3D, 8'h71);
    step(4'b1111, 8'hAA, 8'h55);
    chk8("undef_hold", Result, 8'h31);
    step(4'b0100, 8'h3D, 8'h71);
    async_reset();
    step(4'b0010, 8'h11, 8'h01);
    chk8("post_reset_add", Result, 8'h12);

    // Randomized sweep over all 16 opcodes, with occasional mid-cycle resets.
    for (int i = 0; i < 300; i++) begin
      step(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
      if (i % 60 == 59) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
